// File: rtl/vc_flit_queue_if.sv
// vc_flit_queue_if
//   Push/pop handshake and per-VC status bundle for vc_flit_queue.
//   master : producer/consumer side (drives pushes, pop-ready, flushes)
//   slave  : the queue (drives push-ready, pop data, full/count status)
//   Signals:
//     pushed_flit/pushed_vc/pushed_flit_valid -> push request
//     pushed_flit_ready                      <- target VC can accept
//     poped_flit_ready                       -> consumer takes the head
//     poped_flit_valid/poped_flit/poped_vc   <- granted head flit
//     vc_flush                               -> per-VC synchronous clear
//     vc_full/vc_count                       <- per-VC credit status
interface vc_flit_queue_if #(
  parameter int NUM_VC             = 4,
  parameter int NUM_ENTRIES_PER_VC = 4,
  parameter int FLIT_W             = 8
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES_PER_VC + 1);

  typedef logic [FLIT_W-1:0] flit_t;

  flit_t                    pushed_flit;
  logic [VC_W-1:0]          pushed_vc;
  logic                     pushed_flit_valid;
  logic                     pushed_flit_ready;
  logic                     poped_flit_ready;
  logic                     poped_flit_valid;
  flit_t                    poped_flit;
  logic [VC_W-1:0]          poped_vc;
  logic [NUM_VC-1:0]        vc_flush;
  logic [NUM_VC-1:0]        vc_full;
  logic [NUM_VC*CNT_W-1:0]  vc_count;

  modport master (
    output pushed_flit, pushed_vc, pushed_flit_valid, poped_flit_ready, vc_flush,
    input  pushed_flit_ready, poped_flit_valid, poped_flit, poped_vc, vc_full, vc_count
  );

  modport slave (
    input  pushed_flit, pushed_vc, pushed_flit_valid, poped_flit_ready, vc_flush,
    output pushed_flit_ready, poped_flit_valid, poped_flit, poped_vc, vc_full, vc_count
  );
endinterface

// File: rtl/vc_flit_queue.sv
// vc_flit_queue
//   Multi-VC flit buffer: NUM_VC independent FIFOs of NUM_ENTRIES_PER_VC flits,
//   one shared round-robin pop port, per-VC full/count for credit return and
//   a per-VC synchronous flush.
//   Ports:
//     clk  - clock, all state on rising edge
//     rst  - asynchronous active-high reset
//     q    - vc_flit_queue_if.slave (push, pop, flush, status)
//   vc_flit_lane is the per-VC storage element, one instance per VC.

// vc_flit_lane
//   One VC's FIFO. The parent only asserts push_i when not full and pop_i
//   when not empty; flush_i overrides both and zeroes count and pointers.
//   Ports: clk, rst, push_i, pop_i, flush_i, data_i -> head_o, count_o,
//          full_o, empty_o
module vc_flit_lane #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [FLIT_W-1:0] data_i,
  output logic [FLIT_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Data array is not reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

module vc_flit_queue #(
  parameter int NUM_VC             = 4,
  parameter int NUM_ENTRIES_PER_VC = 4,
  parameter int FLIT_W             = 8
) (
  input  logic          clk,
  input  logic          rst,
  vc_flit_queue_if.slave q
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES_PER_VC + 1);

  logic [NUM_VC-1:0]             push_sel, push_en, pop_en, req, full, empty;
  logic [NUM_VC-1:0][FLIT_W-1:0] head;
  logic [NUM_VC-1:0][CNT_W-1:0]  cnt;
  logic [VC_W-1:0]               rr_q, rr_d, lock_vc_q, lock_vc_d, grant;
  logic                          lock_q, lock_d, valid, pop_fire;
  int                            arb_idx;

  genvar i;
  for (i = 0; i < NUM_VC; i++) begin : g_vc
    // Decode compares against real VC numbers only, so an out-of-range
    // pushed_vc selects nothing and is refused.
    assign push_sel[i] = (q.pushed_vc == VC_W'(i));
    assign push_en[i]  = q.pushed_flit_valid & push_sel[i] & ~full[i] & ~q.vc_flush[i];
    assign req[i]      = ~empty[i] & ~q.vc_flush[i];
    assign pop_en[i]   = pop_fire & (grant == VC_W'(i));

    vc_flit_lane #(
      .DEPTH  (NUM_ENTRIES_PER_VC),
      .FLIT_W (FLIT_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_en[i]),
      .pop_i   (pop_en[i]),
      .flush_i (q.vc_flush[i]),
      .data_i  (q.pushed_flit),
      .head_o  (head[i]),
      .count_o (cnt[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Arbiter: a held (locked) grant wins unless its VC is being flushed;
  // otherwise first requester at or after rr_q. The loop runs from the far
  // offset down so the nearest requester is the last (winning) assignment.
  always_comb begin
    grant   = '0;
    valid   = 1'b0;
    arb_idx = 0;
    if (lock_q && !q.vc_flush[lock_vc_q]) begin
      grant = lock_vc_q;
      valid = 1'b1;
    end else begin
      for (int k = NUM_VC - 1; k >= 0; k--) begin
        arb_idx = int'(rr_q) + k;
        if (arb_idx >= NUM_VC) arb_idx = arb_idx - NUM_VC;
        if (req[arb_idx]) begin
          grant = VC_W'(arb_idx);
          valid = 1'b1;
        end
      end
    end
  end

  assign pop_fire = valid & q.poped_flit_ready;

  // Offered-but-not-taken holds the grant; taking it releases the lock.
  always_comb begin
    rr_d      = rr_q;
    lock_d    = valid & ~q.poped_flit_ready;
    lock_vc_d = grant;
    if (pop_fire) rr_d = (grant == VC_W'(NUM_VC - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  // Ready ignores pop on purpose: a full VC refuses even while it drains.
  assign q.pushed_flit_ready = |(push_sel & ~full & ~q.vc_flush);
  assign q.poped_flit_valid  = valid;
  assign q.poped_vc          = grant;
  assign q.poped_flit        = head[grant];
  assign q.vc_full           = full;
  assign q.vc_count          = cnt;
endmodule

// File: tb/tb_vc_flit_queue.sv
// tb_vc_flit_queue
//   Directed scenarios with literal expectations plus a random phase, all
//   shadowed by a per-VC queue model checked every falling edge.
module tb_vc_flit_queue;
  localparam int NUM_VC = 4;
  localparam int DEPTH  = 4;
  localparam int FLIT_W = 8;
  localparam int VC_W   = 2;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vc_flit_queue_if #(.NUM_VC(NUM_VC), .NUM_ENTRIES_PER_VC(DEPTH), .FLIT_W(FLIT_W)) bus ();

  vc_flit_queue #(.NUM_VC(NUM_VC), .NUM_ENTRIES_PER_VC(DEPTH), .FLIT_W(FLIT_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mq[NUM_VC][$];
  int m_rr = 0;
  bit m_lock = 0;
  int m_lock_vc = 0;

  always @(negedge clk) begin
    int gv, pvc;
    bit ev, er;
    if (rst) begin
      chk("rst_valid", bus.poped_flit_valid, 0);
      chk("rst_count", bus.vc_count, 0);
      chk("rst_full", bus.vc_full, 0);
      chk("rst_vc", bus.poped_vc, 0);
      for (int i = 0; i < NUM_VC; i++) mq[i].delete();
      m_rr = 0;
      m_lock = 0;
      m_lock_vc = 0;
    end else begin
      ev = 0;
      gv = 0;
      if (m_lock && !bus.vc_flush[m_lock_vc]) begin
        ev = 1;
        gv = m_lock_vc;
      end else begin
        for (int k = 0; k < NUM_VC; k++) begin
          int idx;
          idx = (m_rr + k) % NUM_VC;
          if (!ev && mq[idx].size() > 0 && !bus.vc_flush[idx]) begin
            ev = 1;
            gv = idx;
          end
        end
      end
      pvc = int'(bus.pushed_vc);
      er  = (mq[pvc].size() < DEPTH) && !bus.vc_flush[pvc];
      for (int i = 0; i < NUM_VC; i++) begin
        chk("m_count", bus.vc_count[i*CNT_W +: CNT_W], mq[i].size());
        chk("m_full", bus.vc_full[i], mq[i].size() == DEPTH);
      end
      chk("m_push_ready", bus.pushed_flit_ready, er);
      chk("m_pop_valid", bus.poped_flit_valid, ev);
      if (ev) begin
        chk("m_pop_vc", bus.poped_vc, gv);
        chk("m_pop_flit", bus.poped_flit, mq[gv][0]);
      end
      if (ev && bus.poped_flit_ready) begin
        void'(mq[gv].pop_front());
        m_rr = (gv + 1) % NUM_VC;
      end
      m_lock    = ev && !bus.poped_flit_ready;
      m_lock_vc = gv;
      if (bus.pushed_flit_valid && er) mq[pvc].push_back(int'(bus.pushed_flit));
      for (int i = 0; i < NUM_VC; i++) if (bus.vc_flush[i]) mq[i].delete();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pushed_flit_valid = 1'b0;
    bus.poped_flit_ready  = 1'b0;
    bus.vc_flush          = '0;
  endtask

  task automatic push(input int vc, input int f);
    bus.pushed_vc         = VC_W'(vc);
    bus.pushed_flit       = FLIT_W'(f);
    bus.pushed_flit_valid = 1'b1;
    tick();
    bus.pushed_flit_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    bus.poped_flit_ready = 1'b1;
    repeat (4 * DEPTH) tick();
    bus.poped_flit_ready = 1'b0;
    chk("drain_cnt", bus.vc_count, 0);
    chk("drain_valid", bus.poped_flit_valid, 0);
  endtask

  int seq3[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    bus.pushed_flit = '0;
    bus.pushed_vc   = '0;
    idle();
    tick();
    tick();
    chk("t0_rst_valid", bus.poped_flit_valid, 0);
    chk("t0_rst_count", bus.vc_count, 0);
    rst = 1'b0;

    // 1: reset in the middle of traffic
    push(1, 'h11); push(1, 'h12); push(1, 'h13);
    chk("t1_cnt1", bus.vc_count[CNT_W +: CNT_W], 3);
    chk("t1_valid", bus.poped_flit_valid, 1);
    rst = 1'b1;
    #1;
    chk("t1_rst_valid", bus.poped_flit_valid, 0);
    chk("t1_rst_cnt", bus.vc_count, 0);
    tick();
    rst = 1'b0;
    bus.pushed_vc = 0; bus.pushed_flit = 'h0A; bus.pushed_flit_valid = 1'b1;
    #1;
    chk("t1_no_bypass", bus.poped_flit_valid, 0);
    tick();
    bus.pushed_flit_valid = 1'b0;
    chk("t1_pop_valid", bus.poped_flit_valid, 1);
    chk("t1_pop_vc", bus.poped_vc, 0);
    chk("t1_pop_flit", bus.poped_flit, 'h0A);
    bus.poped_flit_ready = 1'b1;
    tick();
    bus.poped_flit_ready = 1'b0;
    chk("t1_empty", bus.poped_flit_valid, 0);

    // 2: full VC2
    do_reset();
    for (int k = 0; k < 4; k++) push(2, 'h20 + k);
    chk("t2_full2", bus.vc_full[2], 1);
    chk("t2_cnt2", bus.vc_count[2*CNT_W +: CNT_W], 4);
    bus.pushed_vc = 2; bus.pushed_flit = 'h30; bus.pushed_flit_valid = 1'b1;
    #1;
    chk("t2_ready_vc2", bus.pushed_flit_ready, 0);
    bus.pushed_vc = 0;
    #1;
    chk("t2_ready_vc0", bus.pushed_flit_ready, 1);
    tick();
    bus.pushed_vc = 2; bus.pushed_flit = 'h25; bus.poped_flit_ready = 1'b1;
    #1;
    chk("t2_ready_full_pop", bus.pushed_flit_ready, 0);
    chk("t2_pop_vc", bus.poped_vc, 2);
    chk("t2_pop_flit", bus.poped_flit, 'h20);
    tick();
    idle();
    chk("t2_cnt2_after", bus.vc_count[2*CNT_W +: CNT_W], 3);
    chk("t2_full2_after", bus.vc_full[2], 0);
    chk("t2_cnt0", bus.vc_count[0 +: CNT_W], 1);
    drain();

    // 3: round-robin order over VCs 0,1,3
    do_reset();
    push(0, 'h01); push(0, 'h02); push(1, 'h11); push(1, 'h12); push(3, 'h31); push(3, 'h32);
    bus.poped_flit_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t3_valid", bus.poped_flit_valid, 1);
      chk("t3_vc", bus.poped_vc, seq3[k]);
      tick();
    end
    chk("t3_done", bus.poped_flit_valid, 0);
    bus.poped_flit_ready = 1'b0;

    // 4: locked grant held while other VCs fill
    do_reset();
    push(1, 'h41); push(1, 'h42);
    for (int k = 0; k < 5; k++) begin
      bus.pushed_vc = 0; bus.pushed_flit = FLIT_W'(k + 1); bus.pushed_flit_valid = 1'b1;
      chk("t4_hold_vc", bus.poped_vc, 1);
      chk("t4_hold_flit", bus.poped_flit, 'h41);
      tick();
    end
    bus.pushed_flit_valid = 1'b0;
    chk("t4_hold_vc_end", bus.poped_vc, 1);
    bus.poped_flit_ready = 1'b1;
    tick();
    bus.poped_flit_ready = 1'b0;
    chk("t4_next_vc", bus.poped_vc, 0);
    chk("t4_next_flit", bus.poped_flit, 'h01);
    drain();

    // 5: flush the locked VC
    do_reset();
    push(1, 'h51); push(1, 'h52); push(1, 'h53); push(2, 'h61);
    chk("t5_locked", bus.poped_vc, 1);
    bus.vc_flush = 4'b0010;
    bus.pushed_vc = 1; bus.pushed_flit = 'h54; bus.pushed_flit_valid = 1'b1;
    #1;
    chk("t5_ready", bus.pushed_flit_ready, 0);
    chk("t5_valid_move", bus.poped_flit_valid, 1);
    chk("t5_vc_move", bus.poped_vc, 2);
    tick();
    idle();
    chk("t5_cnt1", bus.vc_count[CNT_W +: CNT_W], 0);
    chk("t5_vc_after", bus.poped_vc, 2);
    chk("t5_flit_after", bus.poped_flit, 'h61);
    drain();

    // 6: random traffic against the model
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      bus.pushed_flit_valid = ($urandom_range(0, 9) < 6);
      bus.pushed_vc         = VC_W'($urandom_range(0, NUM_VC - 1));
      bus.pushed_flit       = FLIT_W'($urandom);
      bus.poped_flit_ready  = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NUM_VC; i++) bus.vc_flush[i] = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
